// File: rtl/prog_delay_line_pkg.sv
// prog_delay_line_pkg: common DSP helper constants/functions shared by the
// delay-line files.
//   clog2(v)      : ceiling log2, constant-evaluable (clog2(1) = 0)
//   addr_width(d) : address width for a d-deep memory, never below 1 bit
package prog_delay_line_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// prog_delay_line_if: sample stream + delay control bundle for prog_delay_line.
//   in_stb, din          : input sample strobe and NCH packed channels
//   set_delay, delay_in  : one-cycle delay load (flushes the line)
//   out_stb, dout        : registered output strobe and delayed samples
//   primed, cur_delay    : line-primed flag and delay in effect
// master = stream source / controller, slave = the delay line.
interface prog_delay_line_if
    import prog_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NCH       = 2,
    parameter int unsigned MAX_DELAY = 64
);
    localparam int unsigned DW = clog2(MAX_DELAY + 1);

    logic                 in_stb;
    logic [NCH*WIDTH-1:0] din;
    logic                 set_delay;
    logic [DW-1:0]        delay_in;
    logic                 out_stb;
    logic [NCH*WIDTH-1:0] dout;
    logic                 primed;
    logic [DW-1:0]        cur_delay;

    modport master (
        output in_stb, din, set_delay, delay_in,
        input  out_stb, dout, primed, cur_delay
    );

    modport slave (
        input  in_stb, din, set_delay, delay_in,
        output out_stb, dout, primed, cur_delay
    );
endinterface

// File: rtl/prog_delay_line_delay_ram.sv
// delay_ram: simple dual-port RAM, one write port and one synchronously
// registered read port. A read and write to the same address in one cycle
// returns the old contents.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read enable/address; rdata_o holds between reads
module delay_ram
    import prog_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = addr_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/prog_delay_line.sv
// prog_delay_line: multi-channel strobe-qualified delay line, delay 0..MAX_DELAY
// samples, changeable at run time (a change flushes the line).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : prog_delay_line_if slave (stream in/out, delay control, status)
module prog_delay_line
    import prog_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NCH       = 2,
    parameter int unsigned MAX_DELAY = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    prog_delay_line_if.slave  bus
);
    localparam int unsigned DW = clog2(MAX_DELAY + 1);
    localparam int unsigned AW = addr_width(MAX_DELAY);
    localparam int unsigned PW = clog2(MAX_DELAY) + 1;
    localparam int unsigned BW = NCH * WIDTH;
    localparam logic [DW-1:0] MAXD = DW'(MAX_DELAY);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] cur_delay_q, cur_delay_d;
    logic          out_stb_q, primed_q, primed_d;
    logic          use_ram_q, use_ram_d;
    logic [BW-1:0] dout_q, dout_d;

    logic [DW-1:0] d_eff, fill_base;
    logic [PW-1:0] rd_sum;
    logic [AW-1:0] rd_addr;
    logic          unmask, rd_en;
    logic [BW-1:0] ram_rdata;

    always_comb begin
        // A delay load takes effect for a same-cycle strobe, so everything
        // below works from the post-load delay and post-flush fill.
        d_eff     = cur_delay_q;
        fill_base = fill_q;
        if (bus.set_delay) begin
            d_eff     = (bus.delay_in > MAXD) ? MAXD : bus.delay_in;
            fill_base = '0;
        end
        cur_delay_d = d_eff;

        // (wr_ptr - D) mod MAX_DELAY as add-then-conditional-subtract.
        rd_sum = PW'(wr_ptr_q) + (PW'(MAX_DELAY) - PW'(d_eff));
        if (rd_sum >= PW'(MAX_DELAY)) begin
            rd_sum = rd_sum - PW'(MAX_DELAY);
        end
        rd_addr = AW'(rd_sum);

        unmask = (d_eff == '0) || (fill_base >= d_eff);
        rd_en  = bus.in_stb && (d_eff != '0) && unmask;

        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_base;
        primed_d  = primed_q;
        use_ram_d = use_ram_q;
        dout_d    = dout_q;
        if (bus.in_stb) begin
            wr_ptr_d  = (wr_ptr_q == AW'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + 1'b1;
            fill_d    = (fill_base == MAXD) ? MAXD : fill_base + 1'b1;
            // primed marks the strobe whose output is the first unmasked one.
            primed_d  = unmask;
            use_ram_d = rd_en;
            dout_d    = (d_eff == '0) ? bus.din : '0;
        end else if (bus.set_delay) begin
            primed_d = (d_eff == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            cur_delay_q <= '0;
            out_stb_q   <= 1'b0;
            primed_q    <= 1'b0;
            use_ram_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            cur_delay_q <= cur_delay_d;
            out_stb_q   <= bus.in_stb;
            primed_q    <= primed_d;
            use_ram_q   <= use_ram_d;
            dout_q      <= dout_d;
        end
    end

    delay_ram #(
        .WIDTH (BW),
        .DEPTH (MAX_DELAY)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (bus.in_stb),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.din),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // The RAM read register is itself the delayed-sample register; the
    // registered select steers between it and the pass-through/zero register.
    assign bus.dout      = use_ram_q ? ram_rdata : dout_q;
    assign bus.out_stb   = out_stb_q;
    assign bus.primed    = primed_q;
    assign bus.cur_delay = cur_delay_q;
endmodule

// File: tb/tb_prog_delay_line.sv
module tb_prog_delay_line;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned NCH       = 2;
    localparam int unsigned MAX_DELAY = 64;
    localparam int unsigned DW        = 7;
    localparam int unsigned BW        = NCH * WIDTH;

    logic clk;
    logic rst_n;

    prog_delay_line_if #(.WIDTH(WIDTH), .NCH(NCH), .MAX_DELAY(MAX_DELAY)) bus ();

    prog_delay_line #(.WIDTH(WIDTH), .NCH(NCH), .MAX_DELAY(MAX_DELAY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: history of accepted samples, delay in effect and the
    // number of samples accepted since the last flush.
    logic [BW-1:0] hist[$];
    int            m_delay;
    int            m_cnt;
    logic [BW-1:0] e_dout;
    logic          e_stb;
    logic          e_primed;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] pack(input int c0, input int c1);
        return {WIDTH'(c1), WIDTH'(c0)};
    endfunction

    task automatic check_outputs();
        check("out_stb",   64'(bus.out_stb),   64'(e_stb));
        check("dout",      64'(bus.dout),      64'(e_dout));
        check("primed",    64'(bus.primed),    64'(e_primed));
        check("cur_delay", 64'(bus.cur_delay), 64'(m_delay));
    endtask

    // One clock cycle of stimulus, model update and output comparison.
    task automatic step(input logic stb, input logic [BW-1:0] data,
                        input logic set, input int dly);
        @(negedge clk);
        bus.in_stb    = stb;
        bus.din       = data;
        bus.set_delay = set;
        bus.delay_in  = DW'(dly);
        if (set) begin
            m_delay = (dly > int'(MAX_DELAY)) ? int'(MAX_DELAY) : dly;
            m_cnt   = 0;
        end
        e_stb = stb;
        if (stb) begin
            if (m_delay == 0) e_dout = data;
            else if (m_cnt >= m_delay) e_dout = hist[hist.size() - m_delay];
            else e_dout = '0;
            e_primed = (m_delay == 0) || (m_cnt >= m_delay);
            hist.push_back(data);
            if (hist.size() > MAX_DELAY) void'(hist.pop_front());
            m_cnt++;
        end else if (set) begin
            e_primed = (m_delay == 0);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        hist.delete();
        m_delay  = 0;
        m_cnt    = 0;
        e_dout   = '0;
        e_stb    = 1'b0;
        e_primed = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 0);
    endtask

    initial begin
        bus.in_stb    = 1'b0;
        bus.din       = '0;
        bus.set_delay = 1'b0;
        bus.delay_in  = '0;
        model_reset();
        rst_n = 1'b0;
        #22;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Delay 3, continuous ramp; ch1 = ch0 + 100.
        step(1'b0, '0, 1'b1, 3);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, pack(i, i + 100), 1'b0, 0);
            if (i == 4) check("ramp_4th", 64'(bus.dout), 64'(pack(1, 101)));
        end

        // Delay 3, strobe every third cycle.
        step(1'b0, '0, 1'b1, 3);
        for (int i = 0; i < 36; i++) begin
            step(i % 3 == 0, pack(i + 500, i + 900), 1'b0, 0);
        end

        // Full-depth delay, then an out-of-range request that clamps.
        step(1'b0, '0, 1'b1, MAX_DELAY);
        for (int i = 0; i < 150; i++) step(1'b1, BW'($urandom), 1'b0, 0);
        step(1'b0, '0, 1'b1, 100);
        check("clamp", 64'(bus.cur_delay), 64'(MAX_DELAY));
        for (int i = 0; i < 140; i++) step(1'b1, BW'($urandom), 1'b0, 0);

        // Delay 0 pass-through.
        step(1'b0, '0, 1'b1, 0);
        for (int i = 0; i < 10; i++) step(($urandom % 2) == 0, BW'($urandom), 1'b0, 0);

        // Primed at 5, then reload 2 with a same-cycle sample of 50.
        step(1'b0, '0, 1'b1, 5);
        for (int i = 0; i < 8; i++) step(1'b1, pack(i + 10, i + 20), 1'b0, 0);
        step(1'b1, pack(50, 50), 1'b1, 2);
        step(1'b1, pack(51, 51), 1'b0, 0);
        step(1'b1, pack(52, 52), 1'b0, 0);
        check("reload_third", 64'(bus.dout), 64'(pack(50, 50)));

        // Repeated load of the same value still flushes.
        step(1'b1, pack(60, 60), 1'b1, 2);
        step(1'b1, pack(61, 61), 1'b0, 0);

        // Randomized traffic with occasional delay reloads.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, BW'($urandom), ($urandom % 97) == 0,
                 int'($urandom % 75));
        end

        // Asynchronous reset between clock edges.
        step(1'b0, '0, 1'b1, 4);
        for (int i = 0; i < 10; i++) step(1'b1, BW'($urandom), 1'b0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        bus.in_stb = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, BW'($urandom), 1'b0, 0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
